// File: rtl/i8088_bus_peripheral.sv
// 8088-style bus slave: decodes a 2^SIZE_LOG2-byte window on ALE and serves byte
// reads/writes from internal storage. Err latches any RD/WR overlap until reset.
module i8088_bus_peripheral #(
  parameter logic [19:0] BASE_ADDR = 20'hF0000,
  parameter int          SIZE_LOG2 = 8,
  parameter logic        IOM_SEL   = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALE,
  input  logic        RD,
  input  logic        WR,
  input  logic        IOM,
  input  logic [19:0] Address,
  inout  wire  [7:0]  Data,
  output logic        Sel,
  output logic        Err
);

  // state | meaning
  // IDLE  | no decoded cycle, strobes ignored
  // ADDR  | address hit latched, waiting for a strobe
  // READ  | rdata driven onto Data while RD is low
  // WRITE | sampling Data while WR is low, commit on WR rising
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam int DEPTH = 1 << SIZE_LOG2;

  logic [1:0]           state, state_nxt;
  logic [SIZE_LOG2-1:0] adr_q;
  logic [7:0]           rdata, wdata;
  logic [7:0]           mem [DEPTH];
  logic                 hit, err_set, mem_we, rd_load, wd_load;

  assign hit = (Address[19:SIZE_LOG2] == BASE_ADDR[19:SIZE_LOG2]) && (IOM == IOM_SEL);

  // ALE wins over everything, so a new address phase aborts a pending write.
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    wd_load   = 1'b0;
    if (ALE) begin
      state_nxt = hit ? ADDR : IDLE;
    end else begin
      case (state)
        ADDR: begin
          if (!RD && !WR) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end else if (!RD) begin
            rd_load   = 1'b1;
            state_nxt = READ;
          end else if (!WR) begin
            state_nxt = WRITE;
          end
        end
        READ: begin
          if (!RD && !WR) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end else if (RD) begin
            state_nxt = IDLE;
          end
        end
        WRITE: begin
          if (!RD && !WR) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end else if (!WR) begin
            wd_load = 1'b1;
          end else begin
            mem_we    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      adr_q <= '0;
      rdata <= '0;
      wdata <= '0;
      Err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ALE)     adr_q <= Address[SIZE_LOG2-1:0];
      if (rd_load) rdata <= mem[adr_q];
      if (wd_load) wdata <= Data;
      if (err_set) Err   <= 1'b1;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive RESET.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[adr_q] <= wdata;
  end

  assign Sel  = (state != IDLE);
  assign Data = (state == READ && !RD) ? rdata : 8'hzz;

endmodule

// File: tb/tb_i8088_bus_peripheral.sv
// Directed bench for i8088_bus_peripheral; the data bus is pulled up so an
// undriven bus reads as 8'hFF.
module tb_i8088_bus_peripheral;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ale = 1'b0;
  logic        rd  = 1'b1;
  logic        wr  = 1'b1;
  logic        iom = 1'b0;
  logic [19:0] adr = '0;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_data = '0;
  wire  [7:0]  data_bus;
  logic        sel, err;
  int          total = 0;
  int          bad = 0;

  localparam logic [7:0] IDLE_BUS = 8'hFF;

  assign data_bus = tb_oe ? tb_data : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  i8088_bus_peripheral dut (
    .CLK(clk), .RESET(rst), .ALE(ale), .RD(rd), .WR(wr), .IOM(iom),
    .Address(adr), .Data(data_bus), .Sel(sel), .Err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [19:0] a, input logic io);
    ale = 1'b1; adr = a; iom = io;
    tick();
    ale = 1'b0;
  endtask

  task automatic bus_write(input logic [19:0] a, input logic [7:0] d);
    addr_phase(a, 1'b0);
    check("wr_sel_addr", sel, 1'b1);
    wr = 1'b0; tb_oe = 1'b1; tb_data = d;
    tick();
    tick();
    check("wr_sel_write", sel, 1'b1);
    wr = 1'b1;
    tick();
    tb_oe = 1'b0;
    check("wr_sel_done", sel, 1'b0);
  endtask

  task automatic bus_read(input logic [19:0] a, input logic [7:0] exp);
    addr_phase(a, 1'b0);
    rd = 1'b0;
    #1;
    check("rd_before_edge", data_bus, IDLE_BUS);
    tick();
    check("rd_data", data_bus, exp);
    check("rd_sel", sel, 1'b1);
    rd = 1'b1;
    tick();
    check("rd_release", data_bus, IDLE_BUS);
    check("rd_sel_done", sel, 1'b0);
  endtask

  task automatic miss(input logic [19:0] a, input logic io);
    addr_phase(a, io);
    check("miss_sel_addr", sel, 1'b0);
    rd = 1'b0;
    tick();
    check("miss_sel_rd", sel, 1'b0);
    check("miss_data", data_bus, IDLE_BUS);
    rd = 1'b1;
    tick();
  endtask

  initial begin
    #2;
    check("rst_sel", sel, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data", data_bus, IDLE_BUS);
    tick();
    rst = 1'b1;
    tick();

    bus_write(20'hF0012, 8'hA5);
    bus_read(20'hF0012, 8'hA5);

    miss(20'hE0012, 1'b0);
    miss(20'hF0012, 1'b1);
    check("miss_err", err, 1'b0);

    bus_write(20'hF0000, 8'h11);
    bus_write(20'hF00FF, 8'h22);
    bus_read(20'hF0000, 8'h11);
    bus_read(20'hF00FF, 8'h22);

    // out-of-window write must not alias onto offset 0
    addr_phase(20'hF0100, 1'b0);
    check("oow_sel", sel, 1'b0);
    wr = 1'b0; tb_oe = 1'b1; tb_data = 8'h77;
    tick(); tick();
    wr = 1'b1;
    tick();
    tb_oe = 1'b0;
    bus_read(20'hF0000, 8'h11);

    // protocol error from ADDR
    addr_phase(20'hF0012, 1'b0);
    rd = 1'b0; wr = 1'b0; tb_oe = 1'b1; tb_data = 8'h3C;
    tick();
    check("perr_err", err, 1'b1);
    check("perr_sel", sel, 1'b0);
    rd = 1'b1; wr = 1'b1; tb_oe = 1'b0;
    tick();
    bus_read(20'hF0012, 8'hA5);

    // protocol error from WRITE after data was sampled
    addr_phase(20'hF0000, 1'b0);
    wr = 1'b0; tb_oe = 1'b1; tb_data = 8'h99;
    tick(); tick();
    tb_oe = 1'b0; rd = 1'b0;
    tick();
    check("perr_wr_sel", sel, 1'b0);
    rd = 1'b1; wr = 1'b1;
    tick();
    bus_read(20'hF0000, 8'h11);
    check("err_sticky", err, 1'b1);

    // abort a write with a new address phase
    addr_phase(20'hF0012, 1'b0);
    wr = 1'b0; tb_oe = 1'b1; tb_data = 8'h5A;
    tick(); tick();
    wr = 1'b1; tb_oe = 1'b0;
    ale = 1'b1; adr = 20'hF00FF;
    tick();
    ale = 1'b0;
    check("abort_sel", sel, 1'b1);
    wr = 1'b0; tb_oe = 1'b1; tb_data = 8'h66;
    tick(); tick();
    wr = 1'b1;
    tick();
    tb_oe = 1'b0;
    bus_read(20'hF0012, 8'hA5);
    bus_read(20'hF00FF, 8'h66);

    // asynchronous reset in the middle of a read
    addr_phase(20'hF00FF, 1'b0);
    rd = 1'b0;
    tick();
    check("mid_rd_data", data_bus, 8'h66);
    #2;
    rst = 1'b0;
    #1;
    check("arst_data", data_bus, IDLE_BUS);
    check("arst_sel", sel, 1'b0);
    check("arst_err", err, 1'b0);
    rd = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    bus_read(20'hF0012, 8'hA5);
    bus_read(20'hF00FF, 8'h66);
    check("post_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i8088_bus_peripheral.md
I8088_BUS_PERIPHERAL -- requirements
Module: i8088_bus_peripheral

Interface
REQ-001 The block SHALL have a parameter BASE_ADDR, default 20'hF0000, giving the decode base; its low SIZE_LOG2 bits SHALL be zero.
REQ-002 The block SHALL have a parameter SIZE_LOG2, default 8, giving the device size as 2^SIZE_LOG2 bytes; the range SHALL be 1..16.
REQ-003 The block SHALL have a parameter IOM_SEL, default 1'b0, selecting the space it responds in: 0 = memory, 1 = I/O.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port ALE, input, 1 bit: address latch enable, active-high.
REQ-007 The block SHALL have port RD, input, 1 bit: read strobe, active-low.
REQ-008 The block SHALL have port WR, input, 1 bit: write strobe, active-low.
REQ-009 The block SHALL have port IOM, input, 1 bit: bus space, 1 = I/O, 0 = memory.
REQ-010 The block SHALL have port Address, input, 20 bits: demultiplexed bus address.
REQ-011 The block SHALL have port Data, inout, 8 bits: bidirectional data bus.
REQ-012 The block SHALL have port Sel, output, 1 bit: high while a decoded cycle for this device is active.
REQ-013 The block SHALL have port Err, output, 1 bit: sticky protocol-error flag.

Function
REQ-014 The block SHALL contain storage of 2^SIZE_LOG2 bytes, indexed by offset = Address[SIZE_LOG2-1:0].
REQ-015 The block SHALL implement the states IDLE, ADDR, READ and WRITE.
REQ-016 On an edge with ALE=1, the block SHALL latch Address and IOM and compute hit = (Address[19:SIZE_LOG2] == BASE_ADDR[19:SIZE_LOG2]) && (IOM == IOM_SEL).
REQ-017 On an ALE=1 edge, the next state SHALL be ADDR if hit, else IDLE; this SHALL apply from any state and abort any cycle in progress without a memory write.
REQ-018 In ADDR with RD=0 and WR=1, the block SHALL move to READ and register rdata = mem[latched offset] on the same edge.
REQ-019 In ADDR with WR=0 and RD=1, the block SHALL move to WRITE.
REQ-020 In ADDR with RD=1 and WR=1, the block SHALL remain in ADDR.
REQ-021 In READ, Data SHALL be driven with rdata while RD=0, and SHALL be 'z at all other times in all states.
REQ-022 Read latency SHALL be one clock: Data is valid after the first edge at which RD=0 is sampled in ADDR.
REQ-023 In READ, RD=1 sampled SHALL return the block to IDLE, and a read SHALL NOT modify storage.
REQ-024 In WRITE, the block SHALL register Data into wdata on every edge with WR=0.
REQ-025 In WRITE, on the first edge with WR=1, the block SHALL write mem[latched offset] = wdata and return to IDLE, i.e. exactly one write per cycle using the last data sampled while WR=0.
REQ-026 RD=0 and WR=0 sampled together in ADDR, READ or WRITE SHALL set Err, return the block to IDLE, and perform no write.
REQ-027 Err SHALL stay set until reset.
REQ-028 Sel SHALL be 1 in ADDR, READ and WRITE, and 0 in IDLE.
REQ-029 Strobes seen in IDLE SHALL be ignored, with Data remaining 'z.
REQ-030 Address and IOM SHALL be used only as latched on ALE; changes after ALE falls SHALL have no effect.

Reset
REQ-031 RESET=0 SHALL immediately, without waiting for a clock, force state IDLE, Sel=0, Err=0, Data='z, rdata=0, wdata=0 and latched address=0.
REQ-032 Reset SHALL NOT alter storage contents, and storage contents after power-up SHALL be undefined.
REQ-033 A cycle in progress when RESET falls SHALL be abandoned with no write.
REQ-034 After RESET rises, the first ALE=1 edge SHALL be honoured normally.

Verification
REQ-035 Write then read at default parameters: ALE with Address=20'hF0012, IOM=0, then WR=0 for 2 cycles with Data=8'hA5, then WR=1 -> mem[12h]=A5; a following read cycle of F0012 -> Data=8'hA5 one clock after RD=0 sampled, Sel=1 during the cycle.
REQ-036 Decode miss: Address=20'hE0012, or Address=20'hF0012 with IOM=1, then RD=0 -> Sel=0, Data remains 'z, Err=0.
REQ-037 Boundary offsets: write 8'h11 to F0000 and 8'h22 to F00FF, then read both -> 8'h11 and 8'h22; an access to F0100 -> no response.
REQ-038 Protocol error: after a hit, drive RD=0 and WR=0 together -> Err=1, state IDLE, target byte unchanged; Err still 1 after later valid cycles.
REQ-039 Abort: during WRITE with WR=0 and Data=8'h5A, assert ALE with a new hit address -> no write to the old offset; the new cycle completes normally.
REQ-040 Reset mid-read: RESET=0 while READ with RD=0 -> Data='z and Sel=0 with no clock edge; storage retains prior values on a read after reset.
